// File: rtl/if_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit: bus widths,
// the zero word and the fetch FSM state encoding.
package if_fetch_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;
  localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

  // B0..B3 issue the four byte reads, B4 collects the last byte,
  // VALID presents the assembled instruction to decode.
  typedef enum logic [2:0] {
    ST_B0    = 3'd0,
    ST_B1    = 3'd1,
    ST_B2    = 3'd2,
    ST_B3    = 3'd3,
    ST_B4    = 3'd4,
    ST_VALID = 3'd5
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [INST_ADDR_BUS_W-1:0] word_align(
    input logic [INST_ADDR_BUS_W-1:0] addr
  );
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Signal bundle between the fetch unit, the byte RAM port and decode.
// Handshake: inst_valid_o is held high with inst_o/pc_o stable until a rising
// clock edge sees id_ready_i=1 (transfer), unless jump_i=1 on that edge, which
// discards the instruction without a transfer.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                       jump_i;
  logic [INST_ADDR_BUS_W-1:0] jump_addr_i;
  logic                       mem_busy_i;
  logic [7:0]                 mem_data_i;
  logic                       mem_req_o;
  logic [INST_ADDR_BUS_W-1:0] mem_addr_o;
  logic                       id_ready_i;
  logic                       inst_valid_o;
  logic [INST_BUS_W-1:0]      inst_o;
  logic [INST_ADDR_BUS_W-1:0] pc_o;

  // Fetch unit side.
  modport slave (
    input  jump_i, jump_addr_i, mem_busy_i, mem_data_i, id_ready_i,
    output mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o
  );

  // Environment side (decode + RAM).
  modport master (
    output jump_i, jump_addr_i, mem_busy_i, mem_data_i, id_ready_i,
    input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch over an 8-bit RAM port: four little-endian byte reads
// build one 32-bit instruction, which is then held for decode. Redirects and
// load/store contention restart the word from its first byte.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  if_fetch_if.slave    bus,
  output fetch_state_e dbg_state
);

  fetch_state_e               state_q, state_d;
  logic [INST_ADDR_BUS_W-1:0] pc_q, pc_d;
  logic [INST_BUS_W-1:0]      buf_q, buf_d;
  logic                       rd_req;
  logic [INST_ADDR_BUS_W-1:0] rd_addr;

  // State, fetch address and byte buffer; reset aborts any fetch at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_B0;
      pc_q    <= ZERO_WORD;
      buf_q   <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Next state, byte capture and read issue; a redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    rd_req  = 1'b0;
    rd_addr = ZERO_WORD;
    if (bus.jump_i) begin
      state_d = ST_B0;
      pc_d    = word_align(bus.jump_addr_i);
      buf_d   = ZERO_WORD;
    end else begin
      case (state_q)
        ST_B0: begin
          if (!bus.mem_busy_i) begin
            rd_req  = 1'b1;
            rd_addr = pc_q;
            state_d = ST_B1;
          end
        end
        ST_B1: begin
          if (bus.mem_busy_i) begin
            state_d = ST_B0;
            buf_d   = ZERO_WORD;
          end else begin
            rd_req      = 1'b1;
            rd_addr     = pc_q + 32'd1;
            buf_d[7:0]  = bus.mem_data_i;
            state_d     = ST_B2;
          end
        end
        ST_B2: begin
          if (bus.mem_busy_i) begin
            state_d = ST_B0;
            buf_d   = ZERO_WORD;
          end else begin
            rd_req      = 1'b1;
            rd_addr     = pc_q + 32'd2;
            buf_d[15:8] = bus.mem_data_i;
            state_d     = ST_B3;
          end
        end
        ST_B3: begin
          if (bus.mem_busy_i) begin
            state_d = ST_B0;
            buf_d   = ZERO_WORD;
          end else begin
            rd_req       = 1'b1;
            rd_addr      = pc_q + 32'd3;
            buf_d[23:16] = bus.mem_data_i;
            state_d      = ST_B4;
          end
        end
        ST_B4: begin
          // The last read was issued in B3; its byte arrives now.
          buf_d[31:24] = bus.mem_data_i;
          state_d      = ST_VALID;
        end
        ST_VALID: begin
          if (bus.id_ready_i) begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_B0;
          end
        end
        default: begin
          state_d = ST_B0;
        end
      endcase
    end
  end

  // Outputs decoded from state; the read port is quiet while reset is held.
  always_comb begin
    bus.mem_req_o    = rst & rd_req;
    bus.mem_addr_o   = (rst & rd_req) ? rd_addr : ZERO_WORD;
    bus.inst_valid_o = (state_q == ST_VALID);
    bus.inst_o       = (state_q == ST_VALID) ? buf_q : ZERO_WORD;
    bus.pc_o         = (state_q == ST_VALID) ? (pc_q + 32'd4) : ZERO_WORD;
    dbg_state        = state_q;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a behavioural fetch model (pc, bytes issued so far,
// instruction-held flag) predicts every output each cycle; a byte-RAM model
// answers the DUT's reads; directed scenarios pin literal values.
module tb_if_fetch;
  import if_fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_state_e dbg_state;
  if_fetch_if bus ();

  if_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // behavioural model
  logic [31:0] m_pc    = 32'd0;
  int          m_phase = 0;      // byte reads issued for the current word
  bit          m_valid = 1'b0;   // a complete word is being offered

  // last sampled DUT outputs
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;
  logic        last_req  = 1'b0;
  logic [31:0] last_addr = 32'd0;

  // RAM contents: the test instruction at 0, a hash elsewhere.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] h;
    w = 32'h00500093;
    if (a < 32'd4) begin
      case (a[1:0])
        2'd0: return w[7:0];
        2'd1: return w[15:8];
        2'd2: return w[23:16];
        default: return w[31:24];
      endcase
    end
    h = a * 32'h9E3779B1;
    return h[31:24] ^ h[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic step(input logic r, input logic j, input logic [31:0] ja,
                      input logic b, input logic rd);
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_inst, e_pc;
    logic [31:0] got;
    @(negedge clk);
    rst              = r;
    bus.jump_i       = j;
    bus.jump_addr_i  = ja;
    bus.mem_busy_i   = b;
    bus.id_ready_i   = rd;
    bus.mem_data_i   = last_req ? ram_byte(last_addr) : 8'($urandom);
    #1;
    e_req = 1'b0; e_addr = 32'd0; e_valid = 1'b0; e_inst = 32'd0; e_pc = 32'd0;
    if (r) begin
      if (m_valid) begin
        e_valid = 1'b1;
        e_inst  = ram_word(m_pc);
        e_pc    = m_pc + 32'd4;
      end else if (m_phase < 4 && !j && !b) begin
        e_req  = 1'b1;
        e_addr = m_pc + 32'(m_phase);
      end
    end
    s_req   = bus.mem_req_o;
    s_addr  = bus.mem_addr_o;
    s_valid = bus.inst_valid_o;
    s_inst  = bus.inst_o;
    s_pc    = bus.pc_o;
    check("mem_req",    32'(s_req),   32'(e_req));
    check("mem_addr",   s_addr,       e_addr);
    check("inst_valid", 32'(s_valid), 32'(e_valid));
    check("inst",       s_inst,       e_inst);
    check("pc",         s_pc,         e_pc);
    // accepted-instruction scoreboard
    if (r && m_valid && rd && !j) exp_q.push_back(ram_word(m_pc));
    if (r && s_valid && rd && !j) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL accept_unexpected: got %h expected none", s_inst);
      end else begin
        got = exp_q.pop_front();
        check("accepted_inst", s_inst, got);
      end
    end
    last_req  = s_req;
    last_addr = s_addr;
    // model advances to the upcoming edge
    if (!r) begin
      m_pc = 32'd0; m_phase = 0; m_valid = 1'b0;
    end else if (j) begin
      m_pc = {ja[31:2], 2'b00}; m_phase = 0; m_valid = 1'b0;
    end else if (m_valid) begin
      if (rd) begin
        m_pc = m_pc + 32'd4; m_phase = 0; m_valid = 1'b0;
      end
    end else if (m_phase == 4) begin
      m_valid = 1'b1;
    end else if (b) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic run_until_valid(input string name, input int budget);
    int k;
    k = 0;
    do begin
      step(1, 0, 32'd0, 0, 0);
      k++;
    end while (!s_valid && k < budget);
    check(name, 32'(s_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] tr_addr [0:6];
  logic        tr_req  [0:6];
  logic        tr_valid[0:6];
  logic [31:0] tr_inst [0:6];
  logic [31:0] tr_pc   [0:6];

  initial begin
    bus.jump_i = 0; bus.jump_addr_i = 0; bus.mem_busy_i = 0;
    bus.mem_data_i = 0; bus.id_ready_i = 0;

    // reset state
    repeat (3) step(0, 0, 32'd0, 0, 0);
    check("rst_state", 32'(dbg_state), 32'(ST_B0));
    check("rst_req",   32'(s_req), 32'd0);

    // first fetch after release, decode always ready
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 32'd0, 0, 1);
      tr_addr[k] = s_addr; tr_req[k] = s_req; tr_valid[k] = s_valid;
      tr_inst[k] = s_inst; tr_pc[k] = s_pc;
    end
    for (int k = 0; k < 4; k++) begin
      check("first_reads_req",  32'(tr_req[k]), 32'd1);
      check("first_reads_addr", tr_addr[k], 32'(k));
    end
    check("b4_no_req",       32'(tr_req[4]),   32'd0);
    check("not_valid_early", 32'(tr_valid[4]), 32'd0);
    check("valid_at_5",      32'(tr_valid[5]), 32'd1);
    check("first_inst",      tr_inst[5], 32'h00500093);
    check("first_pc",        tr_pc[5],   32'd4);
    check("next_read_4",     tr_addr[6], 32'd4);
    check("valid_dropped",   32'(tr_valid[6]), 32'd0);

    // decode stalls three cycles on the second word
    run_until_valid("second_valid", 20);
    repeat (3) begin
      step(1, 0, 32'd0, 0, 0);
      check("stall_pc",   s_pc, 32'd8);
      check("stall_req",  32'(s_req), 32'd0);
      check("stall_inst", s_inst, ram_word(32'd4));
    end
    step(1, 0, 32'd0, 0, 1);
    step(1, 0, 32'd0, 0, 0);
    check("after_accept_addr", s_addr, 32'd8);

    // redirect in B2
    step(1, 0, 32'd0, 0, 0);
    step(1, 1, 32'h103, 0, 0);
    check("jump_no_req", 32'(s_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 32'd0, 0, 0);
      check("jump_reads", s_addr, 32'h100 + 32'(k));
    end
    run_until_valid("jump_valid", 20);
    check("jump_pc", s_pc, 32'h104);

    // load/store contention in B2
    step(1, 0, 32'd0, 0, 1);
    step(1, 0, 32'd0, 0, 0);
    step(1, 0, 32'd0, 0, 0);
    step(1, 0, 32'd0, 1, 0);
    check("busy_req_1", 32'(s_req), 32'd0);
    step(1, 0, 32'd0, 1, 0);
    check("busy_req_2", 32'(s_req), 32'd0);
    step(1, 0, 32'd0, 0, 0);
    check("busy_restart", s_addr, 32'h104);
    run_until_valid("busy_valid", 20);
    check("busy_inst", s_inst, ram_word(32'h104));

    // jump and accept together
    step(1, 1, 32'h200, 0, 1);
    step(1, 0, 32'd0, 0, 0);
    check("jump_over_ready", s_addr, 32'h200);

    // wrap of the fetch address
    step(1, 1, 32'hFFFF_FFFE, 0, 0);
    run_until_valid("wrap_valid", 20);
    check("wrap_pc", s_pc, 32'd0);
    step(1, 0, 32'd0, 0, 1);
    step(1, 0, 32'd0, 0, 0);
    check("wrap_req",  32'(s_req), 32'd1);
    check("wrap_addr", s_addr, 32'd0);

    // asynchronous reset mid-fetch
    step(1, 0, 32'd0, 0, 0);
    step(0, 0, 32'd0, 0, 0);
    check("async_rst_state", 32'(dbg_state), 32'(ST_B0));
    step(0, 0, 32'd0, 0, 0);
    step(1, 0, 32'd0, 0, 0);
    check("post_rst_req",  32'(s_req), 32'd1);
    check("post_rst_addr", s_addr, 32'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic        r, j, b, rd;
      logic [31:0] ja;
      r  = ($urandom_range(0, 399) != 0);
      j  = ($urandom_range(0, 29) == 0);
      b  = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 1) == 1);
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, j, ja, b, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
